uart_tx: RTL
============

# uart_tx

Asynchronous serial transmitter that is the send-side counterpart of the project's 8N1 UART receiver. It accepts one byte at a time over a valid/ready handshake and shifts it out LSB-first as start bit, 8 data bits, and stop bit. It uses the same 100 MHz system clock, the same baud-selection encoding and the same 16x divisor table as the receiver, so the two can be looped back directly.

## Interface
- PERIOD, 16: oversample factor; one bit time = freq_factor × PERIOD clk cycles.
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- brate_selection  input  2  baud select: 0 → 9600, 1 → 115200, 2 → 921600, 3 → treated as 0.
- tx_data  input  8  byte to send; sampled only on the acceptance edge.
- tx_valid  input  1  a byte is offered on tx_data.
- tx_ready  output  1  high only in IDLE; a byte is accepted on the rising edge where tx_valid && tx_ready.
- tx_out  output  1  serial line, registered, idle high.
- busy  output  1  high from the acceptance edge through the last stop-bit cycle.
- freq_factor  output  11  active divisor: 651, 54 or 7. Combinational from brate_selection.

## Operation
- Bit time BIT = freq_factor × PERIOD: 10416, 864 or 112 cycles. Baud counter is 14 bits.
- The divisor is latched into an internal register at acceptance. Changes to brate_selection mid-frame do not affect the current frame. The freq_factor port itself tracks the input live.
- tx_data is latched into a shift register at acceptance. Later changes to tx_data are ignored.
- State machine:
  - IDLE: tx_out=1, tx_ready=1, busy=0. On tx_valid, latch data and divisor, clear the counters, go to START.
  - START: tx_out=0 for BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_out = shift[idx] for BIT cycles each, idx 0..7, LSB first. After idx 7 completes, go to STOP. The 3-bit idx must not wrap into a ninth bit.
  - STOP: tx_out=1 for BIT cycles, then go to IDLE.
- tx_out is driven from a register updated on state/bit transitions. There are no combinational glitches on the line.
- tx_valid held high continuously sends consecutive frames; each byte is accepted exactly once per IDLE visit.
- Reset at any time (mid-frame included) aborts the frame asynchronously: tx_out=1, state=IDLE. The partial frame is not resumed.

## Timing
- Reset values: tx_out=1, tx_ready=1, busy=0, state=IDLE, counters 0, shift register 0.
- Acceptance at edge N: tx_ready falls and busy rises after edge N; tx_out falls after edge N+1 at the latest.
- Start bit low for exactly BIT cycles, ±0. Each data bit lasts exactly BIT cycles. Stop bit lasts exactly BIT cycles.
- Frame length on the line is 10×BIT cycles. After the last stop cycle the block spends 1 cycle in IDLE with tx_ready=1.
- Minimum start-to-start spacing is 10×BIT+1 cycles, e.g. 1121 cycles at 921600.
- tx_valid without tx_ready: no effect; the byte is not latched.
- tx_valid falling in the same cycle as acceptance: the byte is still sent.

## Test plan
- Reset: hold rst_n low with random inputs → tx_out=1, tx_ready=1, busy=0. Release with tx_valid=0 → line stays 1 for 1000 cycles.
- Sel=2, send 0x55 → line shows 0,1,0,1,0,1,0,1,0,1, each exactly 112 cycles, then idle 1. busy high 1120 cycles.
- Sel=1, send 0xA3 → bits 0,1,1,0,0,0,1,0,1,1 at 864 cycles each. freq_factor=54.
- Back-to-back: hold tx_valid high with 0x01 then 0xFF, sel=2 → two frames with start edges 1121 cycles apart. Each byte is sent once.
- Mid-frame change: start 0x0F at sel=2, switch to sel=0 during bit 3 → whole frame at 112-cycle bits. The next frame uses 10416-cycle bits.
- Reset mid-frame during bit 4 → tx_out=1 immediately, tx_ready=1. A new byte 0x3C then sends correctly; loopback into the receiver at sel=2 yields byte_data=0x3C with data_valid pulsing.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: valid/ready byte input, LSB-first shift-out at a
// 16x-oversample-derived bit time selected from the shared baud table.
module uart_tx #(
  parameter int PERIOD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  brate_selection,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_out,
  output logic        busy,
  output logic [10:0] freq_factor
);

  // state | meaning
  // IDLE  | line high, ready for a byte
  // START | start bit (line low) for one bit time
  // DATA  | data bit shift[idx], idx 0..7
  // STOP  | stop bit (line high) for one bit time
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_d;
  logic [13:0] cnt, cnt_d;
  logic [2:0]  idx, idx_d;
  logic [7:0]  shift, shift_d;
  logic [10:0] div_q, div_d;
  logic        line_d;
  logic [13:0] bit_last;
  logic        bit_done;

  always_comb begin
    case (brate_selection)
      2'd1:    freq_factor = 11'd54;
      2'd2:    freq_factor = 11'd7;
      default: freq_factor = 11'd651;
    endcase
  end

  // Bit time comes from the divisor captured at acceptance, not the live select.
  assign bit_last = 14'(int'(div_q) * PERIOD - 1);
  assign bit_done = (cnt == bit_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
      div_q  <= '0;
      tx_out <= 1'b1;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      shift  <= shift_d;
      div_q  <= div_d;
      tx_out <= line_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
    div_d   = div_q;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          state_d = START;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = tx_data;
          div_d   = freq_factor;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt + 14'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx == 3'd7) state_d = STOP;
          else             idx_d   = idx + 3'd1;
        end else begin
          cnt_d = cnt + 14'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 14'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line value is computed from the next state so tx_out is a clean flop.
  always_comb begin
    tx_ready = (state == IDLE);
    busy     = (state != IDLE);
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[idx_d];
      default: line_d = 1'b1;
    endcase
  end

endmodule
